// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA block-copy engine.
// CPU has priority; a starvation counter forces DMA grants and a beat counter bounds locked bursts.
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {ARB, DMA_FORCE, DMA_BURST} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  starve_cnt, starve_nxt;
  logic [BW-1:0]  beat_cnt, beat_nxt;
  logic           creq;

  always_comb begin
    creq      = cpu_req & ~flush;
    cpu_gnt   = creq;
    dma_gnt   = ~creq & dma_req;
    state_nxt = ARB;
    beat_nxt  = '0;

    case (state)
      DMA_BURST: begin
        if (dma_req & dma_lock & (beat_cnt < BW'(MAX_BURST))) begin
          cpu_gnt   = 1'b0;
          dma_gnt   = 1'b1;
          state_nxt = DMA_BURST;
          beat_nxt  = beat_cnt + BW'(1);
        end
      end
      DMA_FORCE: begin
        if (dma_req) begin
          cpu_gnt = 1'b0;
          dma_gnt = 1'b1;
        end
      end
      default: ;
    endcase

    if (dma_gnt || !dma_req)
      starve_nxt = '0;
    else if (starve_cnt == SW'(STARVE_LIMIT))
      starve_nxt = starve_cnt;
    else
      starve_nxt = starve_cnt + SW'(1);

    // Every burst exit (lock drop or forced release) returns to ARB; only ARB/FORCE may open a burst.
    if (state != DMA_BURST) begin
      if (dma_gnt & dma_lock) begin
        state_nxt = DMA_BURST;
        beat_nxt  = BW'(1);
      end else if (starve_nxt == SW'(STARVE_LIMIT)) begin
        state_nxt = DMA_FORCE;
      end
    end

    cpu_stall = creq & ~cpu_gnt;
    dm_addr   = dma_gnt ? dma_addr : cpu_addr;
    dm_be     = dma_gnt ? dma_be   : cpu_be;
    dm_wd     = dma_gnt ? dma_wd   : cpu_wd;
    dm_we     = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    cpu_rdata = dm_rd;
    dma_rdata = dm_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

endmodule
